recoded_float64_to_ieee: RTL



---
 rtl/recoded_float64_to_ieee.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/recoded_float64_to_ieee.sv
`default_nettype none
// ============================================================================
//  Module      : recoded_float64_to_ieee
//  Description : Converts a 65-bit recoded float64 operand back to a 64-bit
//                IEEE-754 binary64 value. Zero, infinity, NaN and normal
//                operands convert in a single cycle. Subnormal results are
//                denormalized by an iterative right shifter that moves at most
//                SHIFT_STEP bit positions per cycle.
//
//  Ports       : clk        - clock
//                reset_n    - asynchronous active-low reset
//                in_valid   - recoded operand valid
//                in_ready   - block can accept an operand this cycle
//                in_data    - recoded operand: [64] sign, [63:52] exp,
//                             [51:0] fract
//                out_valid  - IEEE result valid
//                out_ready  - consumer accepts the result
//                out_data   - IEEE binary64 result
//
//  Parameters  : SHIFT_STEP - maximum right-shift distance per SHIFT cycle
//                             (legal range 1..53)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module recoded_float64_to_ieee #(
    parameter int SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Per-cycle shift limit and the distance at which the hidden bit has
    // left the 53-bit significand entirely.
    localparam logic [5:0]  c_STEP      = 6'(SHIFT_STEP);
    localparam logic [5:0]  c_MAX_SHIFT = 6'd53;
    localparam logic [11:0] c_MIN_NORM  = 12'd1026;
    localparam logic [11:0] c_MAX_NORM  = 12'd3071;
    localparam logic [10:0] c_EXP_BIAS  = 11'd1025;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [52:0] r_sig;      // significand being denormalized, hidden bit at [52]
    logic [5:0]  r_count;    // remaining right-shift distance
    logic        r_sign;     // sign of the operand in flight through SHIFT
    logic [63:0] r_outData;

    // ------------------------------------------------------------------------
    // Input field extraction and classification
    // ------------------------------------------------------------------------
    logic        w_inSign;
    logic [11:0] w_recExp;
    logic [51:0] w_inFract;
    logic        w_isZero;
    logic        w_isInf;
    logic        w_isNaN;
    logic        w_isNormal;
    logic        w_isSubnormal;

    assign w_inSign  = in_data[64];
    assign w_recExp  = in_data[63:52];
    assign w_inFract = in_data[51:0];

    assign w_isZero      = (w_recExp[11:9] == 3'b000);
    assign w_isInf       = (w_recExp[11:9] == 3'b110);
    assign w_isNaN       = (w_recExp[11:9] == 3'b111);
    assign w_isNormal    = (w_recExp >= c_MIN_NORM) && (w_recExp <= c_MAX_NORM);
    assign w_isSubnormal = ~(w_isZero | w_isInf | w_isNaN | w_isNormal);

    // ------------------------------------------------------------------------
    // Subnormal shift distance n = 1026 - recExp, saturated at 53.
    // The subtraction only has meaning for subnormal inputs (recExp in
    // 512..1025), where it lands in 1..514 without wrapping.
    // ------------------------------------------------------------------------
    logic [11:0] w_shiftRaw;
    logic [5:0]  w_shiftSat;

    assign w_shiftRaw = c_MIN_NORM - w_recExp;
    assign w_shiftSat = (w_shiftRaw > {6'd0, c_MAX_SHIFT}) ? c_MAX_SHIFT
                                                           : w_shiftRaw[5:0];

    // ------------------------------------------------------------------------
    // Single-cycle result for every class except subnormal.
    // The IEEE exponent of a normal is (recExp - 1025) mod 2048, which only
    // depends on the low 11 bits of recExp.
    // ------------------------------------------------------------------------
    logic [10:0] w_normExp;
    logic [63:0] w_directResult;

    assign w_normExp = w_recExp[10:0] - c_EXP_BIAS;

    always_comb begin
        w_directResult = {w_inSign, 63'd0};
        if (w_isInf) begin
            w_directResult = {w_inSign, 11'h7FF, 52'd0};
        end else if (w_isNaN) begin
            // Payload and quiet bit pass through untouched; sNaN stays signaling.
            w_directResult = {w_inSign, 11'h7FF, w_inFract};
        end else if (w_isNormal) begin
            w_directResult = {w_inSign, w_normExp, w_inFract};
        end
    end

    // ------------------------------------------------------------------------
    // Iterative shifter datapath: one step of at most SHIFT_STEP positions.
    // ------------------------------------------------------------------------
    logic [5:0]  w_step;
    logic [52:0] w_sigShifted;
    logic [5:0]  w_countNext;

    assign w_step       = (r_count < c_STEP) ? r_count : c_STEP;
    assign w_sigShifted = r_sig >> w_step;
    assign w_countNext  = r_count - w_step;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic w_accept;

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_outData;

    // ------------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_sig     <= 53'd0;
            r_count   <= 6'd0;
            r_sign    <= 1'b0;
            r_outData <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // A DONE result retired by out_ready in the same cycle as
                    // a new accept is handled exactly like an accept from IDLE.
                    if (w_accept) begin
                        if (w_isSubnormal) begin
                            r_sig   <= {1'b1, w_inFract};
                            r_count <= w_shiftSat;
                            r_sign  <= w_inSign;
                            r_state <= S_SHIFT;
                        end else begin
                            r_outData <= w_directResult;
                            r_state   <= S_DONE;
                        end
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                S_SHIFT: begin
                    r_sig   <= w_sigShifted;
                    r_count <= w_countNext;
                    // Bits shifted past [0] are simply dropped: no rounding.
                    if (w_countNext == 6'd0) begin
                        r_outData <= {r_sign, 11'd0, w_sigShifted[51:0]};
                        r_state   <= S_DONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
